// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/execute controller for the simple CPU.
// It fetches a 16-bit instruction and reads operands A and B from data memory.
// It launches the ALU, waits for alu_done (bounded by ALU_TIMEOUT), and writes the result back.
// Execution stops on a HALT opcode, after the last program slot, or on an error.
module cpu_sequencer #(
  parameter int DATA_W      = 8,
  parameter int LAST_PC     = 15,
  parameter int ALU_TIMEOUT = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [3:0]        program_counter,
  input  logic [15:0]       instruction,
  output logic              mem_rd_en,
  output logic [3:0]        mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [3:0]        alu_op,
  output logic [DATA_W-1:0] operand_a,
  output logic [DATA_W-1:0] operand_b,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [DATA_W-1:0] alu_result,
  output logic              wr_en,
  output logic [3:0]        wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              halted,
  output logic [1:0]        error_code
);

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_FETCH = 4'd1;
  localparam logic [3:0] S_RD_A  = 4'd2;
  localparam logic [3:0] S_RD_B  = 4'd3;
  localparam logic [3:0] S_LATCH = 4'd4;
  localparam logic [3:0] S_EXEC  = 4'd5;
  localparam logic [3:0] S_WAIT  = 4'd6;
  localparam logic [3:0] S_WRITE = 4'd7;
  localparam logic [3:0] S_HALT  = 4'd8;

  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_HALT = 4'd15;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_DIV0    = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  localparam int             CNT_W    = $clog2(ALU_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_TIMEOUT - 1);
  localparam logic [3:0]     PC_LAST  = 4'(LAST_PC);

  logic [3:0]        state_q, state_d;
  logic [3:0]        pc_q, pc_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [3:0]        alu_op_q, alu_op_d;
  logic [1:0]        err_q, err_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              div_by_zero;

  // A DIV whose divisor is zero must never reach the ALU.
  assign div_by_zero = (alu_op_q == OP_DIV) && (op_b_q == '0);

  // Next-state and datapath register updates, one branch per FSM state.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    result_d = result_q;
    alu_op_d = alu_op_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: begin
        pc_d = 4'd0;
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        ir_d = instruction;
        if (instruction[15:12] == OP_HALT) begin
          err_d   = ERR_NONE;
          state_d = S_HALT;
        end else if (instruction[15:12] <= OP_DIV) begin
          alu_op_d = instruction[15:12];
          state_d  = S_RD_A;
        end else begin
          err_d   = ERR_ILLEGAL;
          state_d = S_HALT;
        end
      end
      S_RD_A:  state_d = S_RD_B;
      S_RD_B: begin
        op_a_d  = mem_rdata;
        state_d = S_LATCH;
      end
      S_LATCH: begin
        op_b_d  = mem_rdata;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        if (div_by_zero) begin
          err_d   = ERR_DIV0;
          state_d = S_HALT;
        end else begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (alu_done) begin
          result_d = alu_result;
          state_d  = S_WRITE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = ERR_TIMEOUT;
          state_d = S_HALT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_WRITE: begin
        // Halt check comes before the increment so the PC never wraps.
        if (pc_q == PC_LAST) begin
          state_d = S_HALT;
        end else begin
          pc_d    = pc_q + 4'd1;
          state_d = S_FETCH;
        end
      end
      S_HALT: begin
        if (start) begin
          pc_d    = 4'd0;
          err_d   = ERR_NONE;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pc_q     <= 4'd0;
      ir_q     <= 16'd0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      result_q <= '0;
      alu_op_q <= 4'd0;
      err_q    <= ERR_NONE;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      result_q <= result_d;
      alu_op_q <= alu_op_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  // Outputs come only from registers or state decode, never straight from inputs.
  always_comb begin
    mem_rd_en = (state_q == S_RD_A) || (state_q == S_RD_B);
    mem_addr  = 4'd0;
    if (state_q == S_RD_A) mem_addr = ir_q[11:8];
    if (state_q == S_RD_B) mem_addr = ir_q[7:4];
  end

  assign program_counter = pc_q;
  assign alu_op          = alu_op_q;
  assign operand_a       = op_a_q;
  assign operand_b       = op_b_q;
  assign alu_start       = (state_q == S_EXEC) && !div_by_zero;
  assign wr_en           = (state_q == S_WRITE);
  assign wr_addr         = ir_q[3:0];
  assign wr_data         = result_q;
  assign busy            = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted          = (state_q == S_HALT);
  assign error_code      = err_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
module tb_cpu_sequencer;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [3:0]        program_counter;
  logic [15:0]       instruction;
  logic              mem_rd_en;
  logic [3:0]        mem_addr;
  logic [DATA_W-1:0] mem_rdata;
  logic [3:0]        alu_op;
  logic [DATA_W-1:0] operand_a, operand_b;
  logic              alu_start;
  logic              alu_done;
  logic [DATA_W-1:0] alu_result;
  logic              wr_en;
  logic [3:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              busy, halted;
  logic [1:0]        error_code;

  int checks = 0;
  int errors = 0;

  logic [15:0]       imem [16];
  logic [DATA_W-1:0] dmem [16];
  logic              alu_never;
  logic              alu_force;
  logic              alu_done_q;
  logic [DATA_W-1:0] alu_res_q;
  int                wr_cnt = 0;
  int                start_cnt = 0;

  always #5 clk = ~clk;

  cpu_sequencer #(.DATA_W(DATA_W), .LAST_PC(15), .ALU_TIMEOUT(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .program_counter(program_counter), .instruction(instruction),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .alu_op(alu_op), .operand_a(operand_a), .operand_b(operand_b),
    .alu_start(alu_start), .alu_done(alu_done), .alu_result(alu_result),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .halted(halted), .error_code(error_code)
  );

  // Environment models: combinational instruction ROM, one-cycle data memory, one-cycle ALU.
  assign instruction = imem[program_counter];
  assign alu_done    = alu_done_q | alu_force;
  assign alu_result  = alu_res_q;

  function automatic logic [DATA_W-1:0] alu_calc(input logic [3:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return DATA_W'(a * b);
      4'd5: return (b == 0) ? '0 : a / b;
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= dmem[mem_addr];
    alu_done_q <= alu_start && !alu_never;
    alu_res_q  <= alu_calc(alu_op, operand_a, operand_b);
    if (wr_en) wr_cnt++;
    if (alu_start) start_cnt++;
  end

  task automatic step();
    @(negedge clk);
  endtask

  // Pulse start for one cycle; returns at the negedge where the FSM sits in FETCH.
  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) step();
    checks++; if (busy !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_flags busy=%b halted=%b expected 0 0", busy, halted); end
    checks++; if (program_counter !== 4'd0 || error_code !== 2'd0) begin errors++; $display("FAIL reset_pc_err pc=%0d err=%0d expected 0 0", program_counter, error_code); end
    checks++; if (wr_en !== 1'b0 || alu_start !== 1'b0 || mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_strobes wr=%b st=%b rd=%b expected 0", wr_en, alu_start, mem_rd_en); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_add();
    int w0;
    dmem[0] = 8'd5; dmem[1] = 8'd3;
    imem[0] = 16'h0012; imem[1] = 16'hF000;
    alu_never = 1'b0;
    w0 = wr_cnt;
    kick();
    checks++; if (busy !== 1'b1 || program_counter !== 4'd0) begin errors++; $display("FAIL add_fetch busy=%b pc=%0d expected 1 0", busy, program_counter); end
    step();
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 4'd0) begin errors++; $display("FAIL add_rd_a rd=%b addr=%0d expected 1 0", mem_rd_en, mem_addr); end
    step();
    checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 4'd1) begin errors++; $display("FAIL add_rd_b rd=%b addr=%0d expected 1 1", mem_rd_en, mem_addr); end
    step();
    checks++; if (operand_a !== 8'd5 || mem_rd_en !== 1'b0) begin errors++; $display("FAIL add_opa a=%0d rd=%b expected 5 0", operand_a, mem_rd_en); end
    step();
    checks++; if (operand_b !== 8'd3 || alu_start !== 1'b1 || alu_op !== 4'd0) begin errors++; $display("FAIL add_exec b=%0d start=%b op=%0d expected 3 1 0", operand_b, alu_start, alu_op); end
    step();
    checks++; if (alu_start !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL add_wait start=%b wr=%b expected 0 0", alu_start, wr_en); end
    step();
    checks++; if (wr_en !== 1'b1 || wr_addr !== 4'd2 || wr_data !== 8'd8) begin errors++; $display("FAIL add_write wr=%b addr=%0d data=%0d expected 1 2 8", wr_en, wr_addr, wr_data); end
    step();
    checks++; if (wr_en !== 1'b0 || busy !== 1'b1 || program_counter !== 4'd1) begin errors++; $display("FAIL add_b2b_fetch wr=%b busy=%b pc=%0d expected 0 1 1", wr_en, busy, program_counter); end
    step();
    checks++; if (halted !== 1'b1 || busy !== 1'b0 || error_code !== 2'd0 || program_counter !== 4'd1) begin errors++; $display("FAIL add_halt halted=%b busy=%b err=%0d pc=%0d expected 1 0 0 1", halted, busy, error_code, program_counter); end
    checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL add_wrcount got=%0d expected 1", wr_cnt - w0); end
  endtask

  task automatic test_div_zero();
    int w0, s0;
    imem[0] = 16'h5010; dmem[0] = 8'd9; dmem[1] = 8'd0;
    w0 = wr_cnt; s0 = start_cnt;
    kick();
    repeat (4) step();
    checks++; if (halted !== 1'b0 || alu_start !== 1'b0) begin errors++; $display("FAIL div_exec halted=%b start=%b expected 0 0", halted, alu_start); end
    step();
    checks++; if (halted !== 1'b1 || error_code !== 2'b10) begin errors++; $display("FAIL div_halt halted=%b err=%0d expected 1 2", halted, error_code); end
    repeat (3) step();
    checks++; if (wr_cnt !== w0 || start_cnt !== s0) begin errors++; $display("FAIL div_nowrite writes=%0d starts=%0d expected 0 0", wr_cnt - w0, start_cnt - s0); end
  endtask

  task automatic test_illegal();
    imem[0] = 16'h7000;
    kick();
    checks++; if (halted !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ill_fetch halted=%b busy=%b expected 0 1", halted, busy); end
    step();
    checks++; if (halted !== 1'b1 || error_code !== 2'b01) begin errors++; $display("FAIL ill_halt halted=%b err=%0d expected 1 1", halted, error_code); end
  endtask

  task automatic test_timeout();
    int w0;
    imem[0] = 16'h0012; imem[1] = 16'hF000;
    dmem[0] = 8'd5; dmem[1] = 8'd3;
    alu_never = 1'b1;
    w0 = wr_cnt;
    kick();
    repeat (36) step();
    checks++; if (halted !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_last_wait halted=%b busy=%b expected 0 1", halted, busy); end
    step();
    checks++; if (halted !== 1'b1 || error_code !== 2'b11 || wr_cnt !== w0) begin errors++; $display("FAIL tmo_halt halted=%b err=%0d writes=%0d expected 1 3 0", halted, error_code, wr_cnt - w0); end
    alu_never = 1'b0;
    kick();
    checks++; if (error_code !== 2'b00 || program_counter !== 4'd0 || busy !== 1'b1) begin errors++; $display("FAIL tmo_restart err=%0d pc=%0d busy=%b expected 0 0 1", error_code, program_counter, busy); end
    repeat (8) step();
    checks++; if (halted !== 1'b1 || wr_cnt - w0 !== 1) begin errors++; $display("FAIL tmo_rerun halted=%b writes=%0d expected 1 1", halted, wr_cnt - w0); end
  endtask

  task automatic test_full_program();
    int w0;
    bit done_ok;
    for (int i = 0; i < 16; i++) imem[i] = 16'h0012;
    w0 = wr_cnt;
    done_ok = 1'b0;
    kick();
    for (int i = 0; i < 300; i++) begin
      step();
      if (halted) begin done_ok = 1'b1; break; end
    end
    checks++; if (!done_ok) begin errors++; $display("FAIL full_halt_timeout halted=%b expected 1 within 300 cycles", halted); end
    checks++; if (wr_cnt - w0 !== 16 || program_counter !== 4'd15 || error_code !== 2'd0) begin errors++; $display("FAIL full_result writes=%0d pc=%0d err=%0d expected 16 15 0", wr_cnt - w0, program_counter, error_code); end
    repeat (3) step();
    checks++; if (program_counter !== 4'd15 || halted !== 1'b1) begin errors++; $display("FAIL full_nowrap pc=%0d halted=%b expected 15 1", program_counter, halted); end
  endtask

  task automatic test_reset_in_wait();
    int w0;
    imem[0] = 16'h0012; dmem[0] = 8'd5; dmem[1] = 8'd3;
    alu_never = 1'b1;
    w0 = wr_cnt;
    kick();
    repeat (5) step();
    checks++; if (busy !== 1'b1 || operand_a !== 8'd5) begin errors++; $display("FAIL rstw_prewait busy=%b a=%0d expected 1 5", busy, operand_a); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || halted !== 1'b0 || operand_a !== 8'd0 || operand_b !== 8'd0 || alu_op !== 4'd0) begin errors++; $display("FAIL rstw_async busy=%b halted=%b a=%0d b=%0d op=%0d expected all 0", busy, halted, operand_a, operand_b, alu_op); end
    step();
    rst_n = 1'b1;
    alu_force = 1'b1;
    step();
    alu_force = 1'b0;
    repeat (3) step();
    checks++; if (busy !== 1'b0 || halted !== 1'b0 || program_counter !== 4'd0 || error_code !== 2'd0 || wr_cnt !== w0 || wr_data !== 8'd0) begin errors++; $display("FAIL rstw_idle busy=%b halted=%b pc=%0d err=%0d writes=%0d wd=%0d expected 0 0 0 0 0 0", busy, halted, program_counter, error_code, wr_cnt - w0, wr_data); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; alu_never = 1'b0; alu_force = 1'b0;
    mem_rdata = '0; alu_done_q = 1'b0; alu_res_q = '0;
    for (int i = 0; i < 16; i++) begin imem[i] = 16'hF000; dmem[i] = '0; end
    test_reset();
    test_add();
    test_div_zero();
    test_illegal();
    test_timeout();
    test_full_program();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Fetch/execute controller for the simple CPU. Drives the 4-bit program counter into the instruction register and latches the returned 16-bit instruction. Reads two operands from data memory, launches the ALU and waits for its completion handshake, then writes the result back. Advances through the program until a HALT opcode, the last program slot, or an error.

## Interface
- DATA_W, 8, operand/result width
- LAST_PC, 15, address of final program slot; sequencer halts after executing it
- ALU_TIMEOUT, 32, max WAIT cycles for alu_done before error halt (≥1)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begins program at PC 0 from IDLE or HALT; ignored while running
- program_counter  out  4  instruction address to instruction register
- instruction  in  16  combinational instruction for program_counter
- mem_rd_en  out  1  data-memory read strobe
- mem_addr  out  4  data-memory read address
- mem_rdata  in  DATA_W  read data, valid the cycle after mem_rd_en
- alu_op  out  4  opcode held stable from EXEC through WAIT
- operand_a, operand_b  out  DATA_W  registered operands
- alu_start  out  1  one-cycle launch pulse
- alu_done  in  1  ALU result valid
- alu_result  in  DATA_W  ALU result, sampled when alu_done=1 in WAIT
- wr_en  out  1  one-cycle write strobe
- wr_addr  out  4  write-back address
- wr_data  out  DATA_W  write-back data
- busy  out  1  high in every state except IDLE and HALT
- halted  out  1  high in HALT
- error_code  out  2  00 none, 01 illegal opcode, 10 divide by zero, 11 ALU timeout

## Operation
- Instruction fields: [15:12] opcode, [11:8] addr A, [7:4] addr B, [3:0] destination D.
- Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 MUL, 5 DIV, 15 HALT, 6–14 illegal.
- States: IDLE, FETCH, RD_A, RD_B, LATCH, EXEC, WAIT, WRITE, HALT.
- IDLE: PC=0. start → FETCH.
- FETCH: IR ← instruction.
  - HALT opcode → HALT, error 00.
  - Illegal opcode → HALT, error 01.
  - Otherwise → RD_A.
- RD_A: mem_rd_en=1, mem_addr=A → RD_B.
- RD_B: mem_rd_en=1, mem_addr=B; operand_a ← mem_rdata → LATCH.
- LATCH: operand_b ← mem_rdata → EXEC.
- EXEC:
  - If opcode DIV and operand_b==0: no alu_start; → HALT, error 10.
  - Otherwise: alu_start=1, timeout counter cleared → WAIT.
- WAIT: alu_done sampled starting here; an alu_done in the EXEC cycle is ignored.
  - alu_done=1: result reg ← alu_result → WRITE.
  - Counter increments each WAIT cycle without done. Reaching ALU_TIMEOUT → HALT, error 11, no write.
- WRITE: wr_en=1, wr_addr=D, wr_data=result.
  - PC==LAST_PC → HALT, error 00, PC unchanged.
  - Otherwise PC ← PC+1 → FETCH.
- HALT: halted=1, outputs otherwise idle. start → PC ← 0, error_code ← 00 → FETCH.
- Arithmetic: PC is 4-bit. With LAST_PC=15 the halt check precedes the increment, so PC never wraps. The sequencer performs no arithmetic on data.
- Reset (any state, mid-instruction included): state IDLE; PC, IR, operands, result, alu_op, error_code, and counter all 0; every strobe, busy, and halted = 0. A pending ALU operation is abandoned. alu_done after reset is ignored until the next EXEC.

## Timing
- All outputs registered or decoded from the state register. No combinational path from inputs to outputs.
- start sampled in cycle t → FETCH at t+1.
- Instruction latency with alu_done on the first WAIT cycle: 7 cycles, FETCH through WRITE inclusive. Each extra ALU cycle adds 1.
- mem_rdata is captured exactly 1 cycle after its mem_rd_en.
- Back-to-back instructions: WRITE of n is followed directly by FETCH of n+1.
- start held high continuously: acts only on the cycle the FSM is in IDLE or HALT.

## Test plan
- mem[0]=5, mem[1]=3; instr0=0x0012 (ADD 0,1→2), instr1=0xF000; ALU done 1 cycle after start → alu_op=0, operand_a=5, operand_b=3, wr_en with wr_addr=2 and wr_data=8 (ALU model) 6 cycles after FETCH; then HALT with error 00 and PC=1.
- instr0=0x5010 (DIV), mem[1]=0 → no alu_start, halted=1, error_code=10, wr_en never asserted.
- instr0=0x7000 → HALT the cycle after FETCH, error_code=01.
- ALU never asserts done, ALU_TIMEOUT=32 → error_code=11 after 32 WAIT cycles, no write; a following start restarts at PC 0 with error cleared.
- 16 ADD instructions, LAST_PC=15 → 16 writes, PC stops at 15, halted=1, no wrap to 0.
- rst_n low during WAIT, then released, with alu_done pulsed after release → all outputs 0, state IDLE, no write.
